fir_feeder: RTL and testbench
=============================

FIR_FEEDER -- requirements
Module: fir_feeder

Interface
REQ-001 Parameter TAP_SIZE, 6, coefficient width; must match the FIR's TAP_SIZE.
REQ-002 Parameter NBR_OF_TAPS, 3, number of coefficients per load.
REQ-003 Parameter X_N_SIZE, 8, sample and bus width.
REQ-004 Parameter FIFO_DEPTH, 4, sample FIFO entries; power of two, minimum 2.
REQ-005 Parameter SETUP_CYCLES, 4, post-reset hold-off that covers the FIR's SETUP state.
REQ-006 Clocking and reset: reset reset, synchronous, active-high; clock clk.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 in_data  in  X_N_SIZE  host byte, either a sample or a coefficient.
REQ-010 in_is_coeff  in  1  1 = in_data is a coefficient; 0 = in_data is a sample.
REQ-011 in_valid  in  1  host data is valid.
REQ-012 in_ready  out  1  block accepts in_data this cycle; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-013 x_n  out  X_N_SIZE  registered, signed, drives the FIR's x_n.
REQ-014 s_axis_fir_tvalid  out  1  registered, drives the FIR's sample-valid input.
REQ-015 s_set_coeffs  out  1  registered, drives the FIR's coefficient-load input.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 fifo_count  out  clog2(FIFO_DEPTH)+1  number of samples held in the FIFO.

Function
REQ-018 States SHALL be WAIT_SETUP, IDLE, LOAD, GAP and STREAM.
REQ-019 WAIT_SETUP: outputs low, in_ready low; go to IDLE after SETUP_CYCLES cycles.
REQ-020 In IDLE, coefficient transfers SHALL be accepted only when fifo_count is 0.
- Store in_data[TAP_SIZE-1:0] in the staging slot indexed by coeff_cnt, then increment coeff_cnt.
REQ-021 When coeff_cnt reaches NBR_OF_TAPS, go to LOAD on the next edge and clear coeff_cnt.
REQ-022 LOAD SHALL last exactly NBR_OF_TAPS cycles.
- s_set_coeffs = 1 and tvalid = 0.
- x_n = staging slot 0, 1, ... in capture order, each sign-extended to X_N_SIZE.
- Result: the first coefficient captured lands in the FIR's highest tap.
REQ-023 GAP: one cycle with all FIR outputs low, then IDLE; this lets the FIR leave CONFIG.
REQ-024 Sample transfers SHALL be accepted in IDLE and STREAM whenever fifo_count < FIFO_DEPTH, using the registered count.
REQ-025 In LOAD, GAP and WAIT_SETUP, in_ready SHALL be 0 for both data kinds.
REQ-026 In STREAM, coefficient transfers SHALL be refused (in_ready = 0) until the block returns to IDLE.
REQ-027 Whenever the FIFO is non-empty in IDLE or STREAM, the next edge SHALL pop the head into x_n, set tvalid = 1 and enter or stay in STREAM.
- Latency: a sample accepted at edge k appears on x_n/tvalid after edge k+1.
REQ-028 If the FIFO is empty in STREAM, the next edge SHALL set tvalid = 0, set x_n = 0 and go to IDLE.
REQ-029 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve sample order.
REQ-030 Continuous in_valid samples SHALL produce tvalid high on consecutive cycles with no gaps.
REQ-031 s_set_coeffs and s_axis_fir_tvalid SHALL never be high in the same cycle.
REQ-032 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 Reset SHALL set x_n = 0, tvalid = 0, s_set_coeffs = 0, in_ready = 0, fifo_count = 0, coeff_cnt = 0, setup counter = 0 and state = WAIT_SETUP.
REQ-034 Reset asserted mid-LOAD or mid-STREAM SHALL abort the operation.
- FIFO and staging contents are discarded.
- Outputs are low after the reset edge.
- A coefficient load is never partially resumed.

Structure
REQ-035 Shared package fir_pkg SHALL hold:
- the state encoding localparams;
- default TAP_SIZE, NBR_OF_TAPS and X_N_SIZE, shared with the FIR.
REQ-036 The sample FIFO SHALL be a sub-module fir_feeder_fifo with push, pop, data, count, full and empty.
- Sync reset, no read/write bypass.

Verification
REQ-037 Reset release: in_ready = 0 and all outputs = 0 for 4 cycles, then in_ready = 1 and busy = 0.
REQ-038 Coefficients 0x01, 0x3F, 0x02 -> s_set_coeffs high for 3 cycles with x_n = 0x01, 0xFF, 0x02, then one GAP cycle of zeros, then IDLE.
REQ-039 Samples 0x10, 0x20, 0x30, 0x40 back-to-back -> tvalid high for 4 consecutive cycles, first one cycle after acceptance, x_n in the same order; then tvalid = 0.
REQ-040 Backpressure, with sinks stalled by forcing state: 6 samples pushed with the FIFO draining one per cycle -> no loss or duplication, and fifo_count never exceeds 4.
REQ-041 Coefficient offered while streaming 0x55, 0x66 -> in_ready = 0 until IDLE, then accepted, and the LOAD sequence starts after the 3rd coefficient.
REQ-042 Reset asserted in the 2nd LOAD cycle -> s_set_coeffs = 0 next cycle, state = WAIT_SETUP, staging cleared.
- A subsequent full 3-coefficient load behaves exactly as in REQ-038.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default datapath widths and the feeder state encoding.
package fir_pkg;

    localparam int unsigned DEF_TAP_SIZE    = 6;
    localparam int unsigned DEF_NBR_OF_TAPS = 3;
    localparam int unsigned DEF_X_N_SIZE    = 8;

    localparam logic [2:0] ST_WAIT_SETUP = 3'd0;
    localparam logic [2:0] ST_IDLE       = 3'd1;
    localparam logic [2:0] ST_LOAD       = 3'd2;
    localparam logic [2:0] ST_GAP        = 3'd3;
    localparam logic [2:0] ST_STREAM     = 3'd4;

    typedef enum logic [2:0] {
        StWaitSetup = ST_WAIT_SETUP,
        StIdle      = ST_IDLE,
        StLoad      = ST_LOAD,
        StGap       = ST_GAP,
        StStream    = ST_STREAM
    } feeder_state_e;

endpackage

// File: rtl/fir_feeder_fifo.sv
// Sample FIFO for the FIR feeder: power-of-two depth, registered count, no bypass.
module fir_feeder_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/fir_feeder.sv
// Host-side feeder for the FIR: stages coefficient loads and streams buffered samples.
module fir_feeder
    import fir_pkg::*;
#(
    parameter int unsigned TAP_SIZE     = DEF_TAP_SIZE,
    parameter int unsigned NBR_OF_TAPS  = DEF_NBR_OF_TAPS,
    parameter int unsigned X_N_SIZE     = DEF_X_N_SIZE,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SETUP_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [X_N_SIZE-1:0]           in_data,
    input  logic                          in_is_coeff,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [X_N_SIZE-1:0]    x_n,
    output logic                          s_axis_fir_tvalid,
    output logic                          s_set_coeffs,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned KW = $clog2(NBR_OF_TAPS + 1);
    localparam int unsigned LW = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;
    localparam int unsigned SW = $clog2(SETUP_CYCLES + 1);
    localparam logic [KW-1:0] COEFF_FULL = KW'(NBR_OF_TAPS);
    localparam logic [LW-1:0] LOAD_LAST  = LW'(NBR_OF_TAPS - 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

    feeder_state_e r_state;
    feeder_state_e w_state_next;

    logic [SW-1:0]       r_setup_cnt;
    logic [SW-1:0]       w_setup_cnt_next;
    logic [KW-1:0]       r_coeff_cnt;
    logic [KW-1:0]       w_coeff_cnt_next;
    logic [LW-1:0]       r_load_idx;
    logic [LW-1:0]       w_load_idx_next;
    logic [TAP_SIZE-1:0] r_staging [NBR_OF_TAPS];

    logic [X_N_SIZE-1:0] r_x_n;
    logic [X_N_SIZE-1:0] w_x_n_next;
    logic                r_tvalid;
    logic                w_tvalid_next;
    logic                r_set_coeffs;
    logic                w_set_coeffs_next;

    logic                w_in_ready;
    logic                w_coeff_we;
    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic [X_N_SIZE-1:0] w_fifo_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    function automatic logic [X_N_SIZE-1:0] sext(input logic [TAP_SIZE-1:0] v);
        return {{(X_N_SIZE - TAP_SIZE){v[TAP_SIZE-1]}}, v};
    endfunction

    fir_feeder_fifo #(
        .WIDTH (X_N_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_data  (in_data),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_fifo_push       = in_valid && w_in_ready && !in_is_coeff;
    assign in_ready          = w_in_ready;
    assign x_n               = r_x_n;
    assign s_axis_fir_tvalid = r_tvalid;
    assign s_set_coeffs      = r_set_coeffs;
    assign busy              = (r_state != StIdle);
    assign fifo_count        = w_fifo_count;

    always_comb begin
        w_state_next      = r_state;
        w_setup_cnt_next  = r_setup_cnt;
        w_coeff_cnt_next  = r_coeff_cnt;
        w_load_idx_next   = r_load_idx;
        w_x_n_next        = '0;
        w_tvalid_next     = 1'b0;
        w_set_coeffs_next = 1'b0;
        w_in_ready        = 1'b0;
        w_coeff_we        = 1'b0;
        w_fifo_pop        = 1'b0;

        unique case (r_state)
            StWaitSetup: begin
                if (r_setup_cnt == SETUP_LAST) begin
                    w_state_next = StIdle;
                end else begin
                    w_setup_cnt_next = r_setup_cnt + SW'(1);
                end
            end
            StIdle: begin
                // A full staging set blocks both data kinds for the one cycle before LOAD.
                if (r_coeff_cnt == COEFF_FULL) begin
                    w_state_next      = StLoad;
                    w_coeff_cnt_next  = '0;
                    w_load_idx_next   = '0;
                    w_x_n_next        = sext(r_staging[0]);
                    w_set_coeffs_next = 1'b1;
                end else begin
                    w_in_ready = in_is_coeff ? w_fifo_empty : !w_fifo_full;
                    if (in_valid && w_in_ready && in_is_coeff) begin
                        w_coeff_we       = 1'b1;
                        w_coeff_cnt_next = r_coeff_cnt + KW'(1);
                    end
                    if (!w_fifo_empty) begin
                        w_fifo_pop    = 1'b1;
                        w_x_n_next    = w_fifo_data;
                        w_tvalid_next = 1'b1;
                        w_state_next  = StStream;
                    end
                end
            end
            StStream: begin
                w_in_ready = !in_is_coeff && !w_fifo_full;
                if (!w_fifo_empty) begin
                    w_fifo_pop    = 1'b1;
                    w_x_n_next    = w_fifo_data;
                    w_tvalid_next = 1'b1;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StLoad: begin
                if (r_load_idx == LOAD_LAST) begin
                    w_state_next    = StGap;
                    w_load_idx_next = '0;
                end else begin
                    w_load_idx_next   = r_load_idx + LW'(1);
                    w_x_n_next        = sext(r_staging[w_load_idx_next]);
                    w_set_coeffs_next = 1'b1;
                end
            end
            StGap: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StWaitSetup;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StWaitSetup;
            r_setup_cnt  <= '0;
            r_coeff_cnt  <= '0;
            r_load_idx   <= '0;
            r_x_n        <= '0;
            r_tvalid     <= 1'b0;
            r_set_coeffs <= 1'b0;
            for (int unsigned i = 0; i < NBR_OF_TAPS; i++) begin
                r_staging[i] <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_setup_cnt  <= w_setup_cnt_next;
            r_coeff_cnt  <= w_coeff_cnt_next;
            r_load_idx   <= w_load_idx_next;
            r_x_n        <= w_x_n_next;
            r_tvalid     <= w_tvalid_next;
            r_set_coeffs <= w_set_coeffs_next;
            if (w_coeff_we) begin
                r_staging[r_coeff_cnt[LW-1:0]] <= in_data[TAP_SIZE-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fir_feeder.sv
// Directed and randomized bench for fir_feeder against a queue-based reference model.
module tb_fir_feeder;
    import fir_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_is_coeff;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_n;
    logic       s_axis_fir_tvalid;
    logic       s_set_coeffs;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending samples, captured coefficients, and whether the last edge streamed.
    logic [7:0] mq[$];
    logic [7:0] m_coeffs[$];
    bit         m_stream;

    fir_feeder #(
        .TAP_SIZE     (6),
        .NBR_OF_TAPS  (3),
        .X_N_SIZE     (8),
        .FIFO_DEPTH   (4),
        .SETUP_CYCLES (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_is_coeff       (in_is_coeff),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .x_n               (x_n),
        .s_axis_fir_tvalid (s_axis_fir_tvalid),
        .s_set_coeffs      (s_set_coeffs),
        .busy              (busy),
        .fifo_count        (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sext6(input logic [7:0] c);
        int v;
        v = int'(c) & 63;
        if (v >= 32) v = v - 64;
        return 8'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        check("rst_state", dut.r_state, ST_WAIT_SETUP);
        reset = 1'b0;
        mq.delete();
        m_coeffs.delete();
        m_stream = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_is_coeff = 1'b0;
            #1 check("setup_rdy_smp", in_ready, 0);
            in_is_coeff = 1'b1;
            #1 check("setup_rdy_coef", in_ready, 0);
            check("setup_tvalid", s_axis_fir_tvalid, 0);
            check("setup_set", s_set_coeffs, 0);
            check("setup_xn", x_n, 0);
            check("setup_cnt", fifo_count, 0);
            check("setup_busy", busy, 1);
            tick();
        end
        in_is_coeff = 1'b0;
        #1 check("idle_rdy", in_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    // One handshake cycle outside LOAD/GAP, checked against the model.
    task automatic step(input bit v, input bit c, input logic [7:0] d);
        bit         exp_rdy;
        bit         acc;
        bit         exp_tv;
        logic [7:0] exp_x;
        in_valid = v;
        in_is_coeff = c;
        in_data = d;
        #1;
        exp_rdy = c ? (!m_stream && mq.size() == 0 && m_coeffs.size() < 3) : (mq.size() < 4);
        check(c ? "rdy_coef" : "rdy_smp", in_ready, exp_rdy);
        acc = v && exp_rdy;
        exp_tv = (mq.size() > 0);
        exp_x = exp_tv ? mq.pop_front() : 8'h00;
        if (acc) begin
            if (c) m_coeffs.push_back(d);
            else mq.push_back(d);
        end
        m_stream = exp_tv;
        tick();
        in_valid = 1'b0;
        check("tvalid", s_axis_fir_tvalid, exp_tv);
        check("xn", x_n, exp_x);
        check("set_low", s_set_coeffs, 0);
        check("fifo_cnt", fifo_count, mq.size());
        check("cnt_le_depth", fifo_count <= 3'd4, 1);
        check("busy", busy, m_stream);
    endtask

    task automatic check_load();
        int waited = 0;
        in_valid = 1'b0;
        while (s_set_coeffs !== 1'b1 && waited < 3) begin
            check("pre_load_tvalid", s_axis_fir_tvalid, 0);
            tick();
            waited++;
        end
        check("load_start", s_set_coeffs, 1);
        for (int i = 0; i < 3; i++) begin
            check("load_set", s_set_coeffs, 1);
            check("load_tvalid", s_axis_fir_tvalid, 0);
            check("load_xn", x_n, sext6(m_coeffs[i]));
            check("load_busy", busy, 1);
            in_is_coeff = 1'b0;
            #1 check("load_rdy_smp", in_ready, 0);
            in_is_coeff = 1'b1;
            #1 check("load_rdy_coef", in_ready, 0);
            tick();
        end
        check("gap_set", s_set_coeffs, 0);
        check("gap_tvalid", s_axis_fir_tvalid, 0);
        check("gap_xn", x_n, 0);
        check("gap_busy", busy, 1);
        in_is_coeff = 1'b1;
        #1 check("gap_rdy", in_ready, 0);
        tick();
        in_is_coeff = 1'b0;
        #1 check("post_gap_rdy", in_ready, 1);
        check("post_gap_busy", busy, 0);
        m_coeffs.delete();
        m_stream = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_is_coeff = 1'b0;
        in_data = 8'h00;
        m_stream = 1'b0;

        apply_reset();

        step(1, 1, 8'h01);
        step(1, 1, 8'h3F);
        step(1, 1, 8'h02);
        check_load();

        step(1, 0, 8'h10);
        step(1, 0, 8'h20);
        step(1, 0, 8'h30);
        step(1, 0, 8'h40);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);

        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 9) < 7, 0, 8'($urandom));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00);

        step(1, 0, 8'h55);
        step(1, 0, 8'h66);
        for (int i = 0; i < 6 && m_coeffs.size() == 0; i++) step(1, 1, 8'h07);
        step(1, 1, 8'h1A);
        step(1, 1, 8'h25);
        check_load();

        step(1, 0, 8'hA1);
        step(1, 0, 8'hB2);
        apply_reset();

        step(1, 1, 8'h01);
        step(1, 1, 8'h3F);
        step(1, 1, 8'h02);
        for (int i = 0; i < 3 && s_set_coeffs !== 1'b1; i++) tick();
        check("l2_first", x_n, 8'h01);
        tick();
        check("l2_second_set", s_set_coeffs, 1);
        check("l2_second_xn", x_n, 8'hFF);
        apply_reset();
        for (int i = 0; i < 3; i++) check("stg_clear", dut.r_staging[i], 0);
        check("coeff_cnt_clear", dut.r_coeff_cnt, 0);
        step(1, 1, 8'h01);
        step(1, 1, 8'h3F);
        step(1, 1, 8'h02);
        check_load();

        for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom));
        check_load();
        step(1, 0, 8'h7E);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
